// File: rtl/flow_valve_controller.sv
// flow_valve_controller
// Debounces the 5-bit thermometer flow-sensor code, decodes it to a flow
// level (0..5) and sequences the supply valve through IDLE, STARTUP, RUN,
// ALARM and FAULT states. Low flow in RUN and invalid sensor codes are
// reported as latched conditions that only a host acknowledge clears.
module flow_valve_controller #(
   parameter int DEBOUNCE       = 4,
   parameter int STARTUP_CYCLES = 16,
   parameter int LOW_LIMIT      = 8,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [4:0] ABCDE,
   input  logic       ack,
   output logic       valve_open,
   output logic       alarm,
   output logic       fault,
   output logic [2:0] level,
   output logic       in_range,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STARTUP = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_ALARM   = 3'd3;
   localparam logic [2:0] S_FAULT   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOW_MAX    = CNT_W'(LOW_LIMIT);

   // A thermometer code has no 0 below a 1: adding one must not overlap it.
   function automatic logic code_valid(input logic [4:0] code);
      logic [4:0] code_inc;
      code_inc = code + 5'd1;
      return ((code & code_inc) == 5'd0);
   endfunction

   // Number of active taps in the code, i.e. the flow level.
   function automatic logic [2:0] code_level(input logic [4:0] code);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 5; i++) begin
         n = n + {2'b00, code[i]};
      end
      return n;
   endfunction

   logic [4:0]       sample_q, sample_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [4:0]       acc_q, acc_d;
   logic [2:0]       level_q, level_d;
   logic             in_range_q, in_range_d;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
   logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
   logic             valve_q, valve_d;
   logic             alarm_q, alarm_d;
   logic             fault_q, fault_d;

   logic             code_bad_s;
   logic [CNT_W-1:0] start_inc_s;
   logic [CNT_W-1:0] low_nxt_s;

   // Debounce: run length of identical samples; accept once it reaches the window.
   always_comb begin
      sample_d = ABCDE;
      if (ABCDE != sample_q) begin
         deb_d = CNT_ONE;
      end else if (deb_q < DEB_MAX) begin
         deb_d = deb_q + CNT_ONE;
      end else begin
         deb_d = deb_q;
      end
      if (deb_d == DEB_MAX) begin
         acc_d = ABCDE;
      end else begin
         acc_d = acc_q;
      end
   end

   // Decode the accepted code; an invalid code holds the last good level.
   always_comb begin
      code_bad_s = !code_valid(acc_q);
      if (code_bad_s) begin
         level_d    = level_q;
         in_range_d = in_range_q;
      end else begin
         level_d    = code_level(acc_q);
         in_range_d = (code_level(acc_q) >= 3'd2);
      end
   end

   // Valve sequencing FSM: fault beats host disable, which beats state rules.
   always_comb begin
      if (start_cnt_q < START_LAST) begin
         start_inc_s = start_cnt_q + CNT_ONE;
      end else begin
         start_inc_s = start_cnt_q;
      end
      if (in_range_q) begin
         low_nxt_s = CNT_ZERO;
      end else if (low_cnt_q < LOW_MAX) begin
         low_nxt_s = low_cnt_q + CNT_ONE;
      end else begin
         low_nxt_s = low_cnt_q;
      end

      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (code_bad_s) begin
               state_d = S_FAULT;
            end else if (enable) begin
               state_d = S_STARTUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STARTUP: begin
            if (code_bad_s) begin
               state_d = S_FAULT;
            end else if (!enable) begin
               state_d = S_IDLE;
            end else if (start_inc_s == START_LAST) begin
               state_d = S_RUN;
            end else begin
               state_d = S_STARTUP;
            end
         end
         S_RUN: begin
            if (code_bad_s) begin
               state_d = S_FAULT;
            end else if (!enable) begin
               state_d = S_IDLE;
            end else if (low_nxt_s == LOW_MAX) begin
               state_d = S_ALARM;
            end else begin
               state_d = S_RUN;
            end
         end
         S_ALARM: begin
            if (ack) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ALARM;
            end
         end
         S_FAULT: begin
            if (ack && !code_bad_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_FAULT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Counters restart on every state entry and only run in their own state.
      if (state_d != state_q) begin
         start_cnt_d = CNT_ZERO;
         low_cnt_d   = CNT_ZERO;
      end else if (state_q == S_STARTUP) begin
         start_cnt_d = start_inc_s;
         low_cnt_d   = CNT_ZERO;
      end else if (state_q == S_RUN) begin
         start_cnt_d = CNT_ZERO;
         low_cnt_d   = low_nxt_s;
      end else begin
         start_cnt_d = CNT_ZERO;
         low_cnt_d   = CNT_ZERO;
      end

      // Outputs are registered from the next state so they track it without lag.
      valve_d = (state_d == S_STARTUP) || (state_d == S_RUN);
      alarm_d = (state_d == S_ALARM);
      fault_d = (state_d == S_FAULT);
   end

   // State, counters, sensor pipeline and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q    <= 5'd0;
         deb_q       <= CNT_ZERO;
         acc_q       <= 5'd0;
         level_q     <= 3'd0;
         in_range_q  <= 1'b0;
         state_q     <= S_IDLE;
         start_cnt_q <= CNT_ZERO;
         low_cnt_q   <= CNT_ZERO;
         valve_q     <= 1'b0;
         alarm_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         sample_q    <= sample_d;
         deb_q       <= deb_d;
         acc_q       <= acc_d;
         level_q     <= level_d;
         in_range_q  <= in_range_d;
         state_q     <= state_d;
         start_cnt_q <= start_cnt_d;
         low_cnt_q   <= low_cnt_d;
         valve_q     <= valve_d;
         alarm_q     <= alarm_d;
         fault_q     <= fault_d;
      end
   end

   assign valve_open = valve_q;
   assign alarm      = alarm_q;
   assign fault      = fault_q;
   assign level      = level_q;
   assign in_range   = in_range_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_flow_valve_controller.sv
// Testbench for flow_valve_controller: a behavioural model predicts the
// outputs after each clock edge and queues them; the queue is drained and
// compared once the DUT has clocked. Directed checks pin down the key timing
// points (valve rise, debounce latency, startup length, alarm delay).
module tb_flow_valve_controller;

   localparam int DEB = 4;
   localparam int SC  = 16;
   localparam int LL  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [4:0] abcde;
   logic       ack;
   logic       valve_open;
   logic       alarm;
   logic       fault;
   logic [2:0] level;
   logic       in_range;
   logic [2:0] state_o;

   always #5 clk = ~clk;

   flow_valve_controller #(
      .DEBOUNCE(DEB), .STARTUP_CYCLES(SC), .LOW_LIMIT(LL), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .ABCDE(abcde), .ack(ack),
      .valve_open(valve_open), .alarm(alarm), .fault(fault),
      .level(level), .in_range(in_range), .state_o(state_o)
   );

   typedef struct packed {
      logic       valve;
      logic       alarm;
      logic       fault;
      logic [2:0] level;
      logic       inr;
      logic [2:0] state;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state
   int         m_state = 0;
   int         m_sc    = 0;
   int         m_low   = 0;
   int         m_level = 0;
   logic       m_inr   = 1'b0;
   logic [4:0] m_acc   = 5'd0;
   logic [4:0] m_hist[$];

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic logic thermo_ok(input logic [4:0] c);
      return (c == 5'b00000) || (c == 5'b00001) || (c == 5'b00011) ||
             (c == 5'b00111) || (c == 5'b01111) || (c == 5'b11111);
   endfunction

   // Advance the model by one edge for the given inputs and queue its outputs.
   task automatic model_step(input logic en, input logic [4:0] code,
                             input logic a, input logic r);
      exp_t e;
      int   ns;
      int   run;
      logic bad;
      if (r) begin
         m_state = 0; m_sc = 0; m_low = 0; m_level = 0;
         m_inr = 1'b0; m_acc = 5'd0;
         m_hist.delete();
      end else begin
         bad = !thermo_ok(m_acc);
         ns  = m_state;
         case (m_state)
            0: if (bad) ns = 4; else if (en) ns = 1;
            1: if (bad) ns = 4; else if (!en) ns = 0; else if (m_sc + 1 >= SC - 1) ns = 2;
            2: if (bad) ns = 4; else if (!en) ns = 0; else if ((m_inr ? 0 : m_low + 1) >= LL) ns = 3;
            3: if (a) ns = 0;
            4: if (a && !bad) ns = 0;
            default: ns = 0;
         endcase
         if (ns != m_state) begin
            m_sc = 0; m_low = 0;
         end else if (m_state == 1) begin
            m_sc = m_sc + 1;
         end else if (m_state == 2) begin
            m_low = m_inr ? 0 : m_low + 1;
         end
         if (!bad) begin
            m_level = $countones(m_acc);
            m_inr   = (m_level >= 2);
         end
         m_hist.push_back(code);
         run = 0;
         for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != code) break;
            run++;
         end
         if (run >= DEB) m_acc = code;
         if (m_hist.size() > DEB) void'(m_hist.pop_front());
         m_state = ns;
      end
      e.valve = (m_state == 1) || (m_state == 2);
      e.alarm = (m_state == 3);
      e.fault = (m_state == 4);
      e.level = m_level[2:0];
      e.inr   = m_inr;
      e.state = m_state[2:0];
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs, clock, then compare against the queued prediction.
   task automatic step(input logic en, input logic [4:0] code,
                       input logic a, input logic r);
      exp_t e;
      enable = en; abcde = code; ack = a; rst = r;
      model_step(en, code, a, r);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check_val("sb_valve", int'(valve_open), int'(e.valve));
         check_val("sb_alarm", int'(alarm), int'(e.alarm));
         check_val("sb_fault", int'(fault), int'(e.fault));
         check_val("sb_level", int'(level), int'(e.level));
         check_val("sb_inr",   int'(in_range), int'(e.inr));
         check_val("sb_state", int'(state_o), int'(e.state));
      end
   endtask

   initial begin
      logic [4:0] rcode;
      int         hold;
      int         pick;

      // Reset
      step(1'b0, 5'b00000, 1'b0, 1'b1);
      step(1'b0, 5'b00000, 1'b0, 1'b1);
      check_val("rst_state", int'(state_o), 0);
      check_val("rst_valve", int'(valve_open), 0);
      check_val("rst_level", int'(level), 0);
      check_val("rst_alarm_fault", int'({alarm, fault, in_range}), 0);

      // Enable with 3 taps active: startup then run
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 5'b00111, 1'b0, 1'b0);
         if (i == 1)  check_val("s1_valve_rise", int'(valve_open), 1);
         if (i == 4)  check_val("s1_level_early", int'(level), 0);
         if (i == 5) begin
            check_val("s1_level", int'(level), 3);
            check_val("s1_inr", int'(in_range), 1);
         end
         if (i == 15) check_val("s1_still_startup", int'(state_o), 1);
      end
      check_val("s1_run", int'(state_o), 2);

      // Short glitch must not be accepted
      for (int i = 0; i < 4; i++) step(1'b1, 5'b00111, 1'b0, 1'b0);
      step(1'b1, 5'b00001, 1'b0, 1'b0);
      step(1'b1, 5'b00001, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 5'b00111, 1'b0, 1'b0);
         if (i == 3) check_val("s3_glitch_level", int'(level), 3);
      end
      check_val("s3_no_alarm", int'(alarm), 0);
      check_val("s3_state", int'(state_o), 2);

      // Low flow in RUN: alarm LOW_LIMIT cycles after in_range falls
      for (int i = 1; i <= 13; i++) begin
         step(1'b1, 5'b00001, 1'b0, 1'b0);
         if (i == 5) begin
            check_val("s2_level_low", int'(level), 1);
            check_val("s2_inr_low", int'(in_range), 0);
         end
         if (i == 12) check_val("s2_alarm_early", int'(alarm), 0);
      end
      check_val("s2_alarm", int'(alarm), 1);
      check_val("s2_valve_closed", int'(valve_open), 0);
      step(1'b1, 5'b00001, 1'b1, 1'b0);
      check_val("s2_ack_alarm", int'(alarm), 0);
      check_val("s2_ack_idle", int'(state_o), 0);

      // Back to RUN, then an invalid code
      for (int i = 0; i < 20; i++) step(1'b1, 5'b00111, 1'b0, 1'b0);
      check_val("s4_run", int'(state_o), 2);
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 5'b10101, 1'b0, 1'b0);
         if (i == 4) check_val("s4_fault_early", int'(fault), 0);
      end
      check_val("s4_fault", int'(fault), 1);
      check_val("s4_fault_valve", int'(valve_open), 0);
      check_val("s4_fault_level", int'(level), 3);
      step(1'b1, 5'b10101, 1'b1, 1'b0);
      check_val("s4_ack_ignored", int'(state_o), 4);
      for (int i = 0; i < 5; i++) step(1'b1, 5'b11111, 1'b0, 1'b0);
      check_val("s4_level5", int'(level), 5);
      step(1'b0, 5'b11111, 1'b1, 1'b0);
      check_val("s4_exit_idle", int'(state_o), 0);
      check_val("s4_fault_clr", int'(fault), 0);
      check_val("s4_level_kept", int'(level), 5);
      for (int i = 0; i < 8; i++) step(1'b0, 5'b00000, 1'b0, 1'b0);
      check_val("s4_level0", int'(level), 0);

      // Low flow ignored during startup, alarm 8 cycles into RUN
      for (int i = 1; i <= 24; i++) begin
         step(1'b1, 5'b00000, 1'b0, 1'b0);
         if (i == 15) check_val("s5_startup", int'(state_o), 1);
         if (i == 16) check_val("s5_run", int'(state_o), 2);
         if (i == 23) check_val("s5_alarm_early", int'(alarm), 0);
      end
      check_val("s5_alarm", int'(alarm), 1);
      step(1'b0, 5'b00000, 1'b1, 1'b0);

      // Reset mid-RUN discards the debounce history
      for (int i = 0; i < 20; i++) step(1'b1, 5'b01111, 1'b0, 1'b0);
      check_val("s6_run_level", int'(level), 4);
      step(1'b1, 5'b01111, 1'b0, 1'b1);
      check_val("s6_rst_outs",
                int'({valve_open, alarm, fault, level, in_range, state_o}), 0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 5'b01111, 1'b0, 1'b0);
         if (i == 4) check_val("s6_level_hold0", int'(level), 0);
      end
      check_val("s6_level4", int'(level), 4);

      // Randomised traffic against the model
      hold  = 0;
      rcode = 5'd0;
      for (int i = 0; i < 500; i++) begin
         if (hold == 0) begin
            pick = $urandom_range(0, 9);
            case (pick)
               0: rcode = 5'b00000;
               1: rcode = 5'b00001;
               2: rcode = 5'b00011;
               3: rcode = 5'b00111;
               4: rcode = 5'b01111;
               5: rcode = 5'b11111;
               default: rcode = 5'($urandom_range(0, 31));
            endcase
            hold = $urandom_range(1, 14);
         end
         hold--;
         step(($urandom_range(0, 9) != 0), rcode,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/flow_valve_controller.md
Name: flow_valve_controller

Overview:
- Sequencing controller for the thermometer-coded flow sensor: debounces the 5-bit sensor code ABCDE (10/20/30/40/50 L/min taps) and decodes it to a flow level.
- Opens and closes the supply valve through a startup/run/alarm state machine.
- Reports an invalid sensor code as a latched fault.
- Sits between the sensor front end and the valve driver; the host enables it and acknowledges alarms.

Parameters:
- DEBOUNCE, 4: consecutive identical samples required before a code is accepted (>=1).
- STARTUP_CYCLES, 16: cycles after valve opening during which low flow is ignored.
- LOW_LIMIT, 8: consecutive low-flow cycles in RUN that trigger an alarm.
- CNT_W, 8: width of internal counters; must hold max(DEBOUNCE, STARTUP_CYCLES, LOW_LIMIT).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  host request to run flow (level-sensitive).
- ABCDE  in  5  raw thermometer sensor code; bit0 = 10 L/min tap … bit4 = 50 L/min tap.
- ack  in  1  single-cycle host acknowledge; clears ALARM/FAULT.
- valve_open  out  1  valve drive, 1 = open.
- alarm  out  1  low-flow alarm, latched.
- fault  out  1  invalid-sensor-code fault, latched.
- level  out  3  accepted flow level, 0..5 (count of ones in the accepted code).
- in_range  out  1  1 when the accepted level is 2..5 (20–50 L/min).
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset (rst=1 at clock edge), with priority over all else:
  - state=IDLE; all outputs 0.
  - Accepted code = 00000; sample register = 00000; all counters = 0.
- Sampling:
  - ABCDE is registered every cycle into the sample register (1-cycle input latency).
  - Debounce counter increments while the sample equals the previous sample and clears to 1 on change. It saturates at DEBOUNCE.
  - When the counter reaches DEBOUNCE, the sample becomes the accepted code.
  - Minimum latency from a stable ABCDE change to updated level: DEBOUNCE+1 cycles.
- Validity:
  - Valid codes are only 00000, 00001, 00011, 00111, 01111 and 11111.
  - level and in_range are registered from the accepted code.
  - An invalid accepted code leaves level/in_range at their previous values and raises code_bad internally.
- State machine:
  - IDLE (0): valve_open=0. Goes to STARTUP when enable=1.
  - STARTUP (1): valve_open=1; the startup counter counts up. Goes to RUN when the counter reaches STARTUP_CYCLES-1. Low flow is ignored here.
  - RUN (2): valve_open=1. The low counter increments each cycle in_range=0 and clears when in_range=1. Goes to ALARM when the low counter reaches LOW_LIMIT.
  - ALARM (3): valve_open=0, alarm=1. Goes to IDLE on ack=1; alarm clears the same edge.
  - FAULT (4): valve_open=0, fault=1. Goes to IDLE on ack=1 only if the accepted code is valid; otherwise ack is ignored.
- Transition priority each cycle:
  - rst first.
  - Then code_bad in STARTUP/RUN/IDLE → FAULT.
  - Then enable=0 in STARTUP/RUN → IDLE, with no alarm.
  - Then the state-specific rules above.
- ALARM and FAULT ignore enable; only ack exits them.
- Simultaneous events:
  - code_bad on the same cycle the low counter expires → FAULT wins and alarm stays 0.
  - ack while in IDLE/STARTUP/RUN has no effect.
- Counters: the startup and low counters clear on every state entry and never wrap; they saturate at their limit.
- Reset mid-operation:
  - The valve closes on the reset edge.
  - The debounce history is discarded, so the next accepted code needs a full DEBOUNCE window.
- Unused state encodings (5–7) → IDLE on the next edge.

Test Plan:
- Reset then enable=1, ABCDE=00111 stable → valve_open rises 1 cycle after enable. level=3 and in_range=1 by cycle DEBOUNCE+1 (5). state=RUN at cycle 16 after enable.
- In RUN, ABCDE=00001 held → level=1, in_range=0. Alarm=1 and valve_open=0 exactly LOW_LIMIT (8) cycles after in_range falls. ack=1 → alarm=0, state=IDLE next cycle.
- In RUN, ABCDE glitches 00111→00001 for 2 cycles then back → level stays 3, no alarm, low counter stays 0.
- In RUN, ABCDE=10101 held 5 cycles → fault=1, valve_open=0, level stays previous value. ack while 10101 → stays FAULT. ABCDE=11111 for 5 cycles then ack → IDLE, fault=0, level=5.
- In STARTUP with ABCDE=00000 → no alarm during the 16 startup cycles. Alarm asserts 8 cycles after entering RUN.
- rst=1 for 1 cycle mid-RUN with ABCDE=01111 → all outputs 0 next edge. level stays 0 until 4 stable samples, then level=4.
